// File: rtl/prefix_pkg.sv
// Shared parallel-prefix carry-network types and cell functions for the 16-bit
// adder and subtractor family.
package prefix_pkg;

  localparam int PFX_WIDTH = 16;

  typedef struct packed {
    logic [PFX_WIDTH-1:0] g;
    logic [PFX_WIDTH-1:0] p;
  } gp_t;

  // Black cell: merge a higher group (i) with the adjacent lower group (j).
  function automatic logic [1:0] black_cell(input logic gi, input logic pi,
                                            input logic gj, input logic pj);
    return {gi | (pi & gj), pi & pj};
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: every bit at or above SPAN merges with the
// bit SPAN positions below it, doubling the group width covered by each node.
module prefix_level
  import prefix_pkg::*;
#(
  parameter int SPAN = 1
) (
  input  gp_t cur,
  output gp_t nxt
);

  always_comb begin
    nxt = cur;
    for (int i = SPAN; i < PFX_WIDTH; i++) begin
      {nxt.g[i], nxt.p[i]} = black_cell(cur.g[i], cur.p[i], cur.g[i-SPAN], cur.p[i-SPAN]);
    end
  end

endmodule

// File: rtl/prefix_sub16_pipe.sv
// Three-stage pipelined 16-bit subtractor (a - b) on a Kogge-Stone prefix network,
// with valid/ready handshakes and borrow, signed-overflow and zero flags.
module prefix_sub16_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (WIDTH != PFX_WIDTH) begin : g_width_check
    $error("prefix_sub16_pipe: prefix network only supports WIDTH = 16");
  end

  logic v0, v1, v2;
  logic en0, en1, en2;

  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign en0       = !v0 || en1;
  assign in_ready  = en0;
  assign out_valid = v2;

  gp_t                  s0_gp;
  logic                 s0_a_msb, s0_b_msb;
  logic [TAG_W-1:0]     s0_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0       <= 1'b0;
      s0_gp    <= '0;
      s0_a_msb <= 1'b0;
      s0_b_msb <= 1'b0;
      s0_tag   <= '0;
    end else if (en0) begin
      v0       <= in_valid;
      s0_gp.g  <= in_a & ~in_b;
      s0_gp.p  <= in_a ^ ~in_b;
      s0_a_msb <= in_a[WIDTH-1];
      s0_b_msb <= in_b[WIDTH-1];
      s0_tag   <= in_tag;
    end
  end

  // Carry-in of 1 is absorbed into bit 0, so every G[i] below is G[i:-1].
  gp_t s1_cin, s1_l1, s1_l2;

  always_comb begin
    s1_cin      = s0_gp;
    s1_cin.g[0] = s0_gp.g[0] | s0_gp.p[0];
  end

  prefix_level #(.SPAN(1)) u_lvl1 (.cur(s1_cin), .nxt(s1_l1));
  prefix_level #(.SPAN(2)) u_lvl2 (.cur(s1_l1),  .nxt(s1_l2));

  gp_t                  s1_gp;
  logic [PFX_WIDTH-1:0] s1_p;
  logic                 s1_a_msb, s1_b_msb;
  logic [TAG_W-1:0]     s1_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_gp    <= '0;
      s1_p     <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
      s1_tag   <= '0;
    end else if (en1) begin
      v1       <= v0;
      s1_gp    <= s1_l2;
      s1_p     <= s0_gp.p;
      s1_a_msb <= s0_a_msb;
      s1_b_msb <= s0_b_msb;
      s1_tag   <= s0_tag;
    end
  end

  gp_t                  s2_l3, s2_l4;
  logic [PFX_WIDTH-1:0] carry;
  logic [PFX_WIDTH-1:0] diff_c;
  logic                 unused_p;

  prefix_level #(.SPAN(4)) u_lvl3 (.cur(s1_gp), .nxt(s2_l3));
  prefix_level #(.SPAN(8)) u_lvl4 (.cur(s2_l3), .nxt(s2_l4));

  assign carry    = s2_l4.g;
  assign diff_c   = s1_p ^ {carry[PFX_WIDTH-2:0], 1'b1};
  // Group propagate of the final level has no consumer.
  assign unused_p = ^s2_l4.p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else if (en2) begin
      v2         <= v1;
      out_diff   <= diff_c;
      out_borrow <= ~carry[PFX_WIDTH-1];
      out_ovf    <= (s1_a_msb ^ s1_b_msb) & (diff_c[PFX_WIDTH-1] ^ s1_a_msb);
      out_zero   <= (diff_c == '0);
      out_tag    <= s1_tag;
    end
  end

endmodule

// File: tb/tb_prefix_sub16_pipe.sv
// Bench for prefix_sub16_pipe: directed corner cases plus randomized traffic scored
// against an arithmetic reference model with ordered expectation queue.
module tb_prefix_sub16_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_diff;
  logic        out_borrow, out_ovf, out_zero;
  logic [3:0]  out_tag;

  prefix_sub16_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } op_t;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  op_t        src_q[$];
  res_t       exp_q[$];
  logic [3:0] tag_log[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_out = 0;
  bit         presenting = 0;
  bit         held = 0;
  res_t       held_r;
  res_t       last_r;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic int to_signed16(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic res_t model(input op_t op);
    res_t r;
    int   sd;
    sd       = to_signed16(op.a) - to_signed16(op.b);
    r.diff   = op.a - op.b;
    r.borrow = (op.a < op.b);
    r.ovf    = (sd > 32767) || (sd < -32768);
    r.zero   = (op.a == op.b);
    r.tag    = op.tag;
    return r;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    op_t op;
    op.a = a; op.b = b; op.tag = tag;
    src_q.push_back(op);
  endtask

  // One clock: drive at the falling edge, account handshakes just after it.
  task automatic cycle(input bit try_valid);
    res_t r;
    op_t  op;
    if (!presenting && src_q.size() > 0 && try_valid) presenting = 1;
    in_valid = presenting;
    if (presenting) begin
      in_a = src_q[0].a; in_b = src_q[0].b; in_tag = src_q[0].tag;
    end else begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 4'($urandom);
    end
    #1;
    if (!rst_n) begin
      exp_q.delete();
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_diff", out_diff, held_r.diff);
        check("hold_flags", {out_borrow, out_ovf, out_zero},
              {held_r.borrow, held_r.ovf, held_r.zero});
        check("hold_tag", out_tag, held_r.tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          r = exp_q.pop_front();
          check("diff", out_diff, r.diff);
          check("borrow", out_borrow, r.borrow);
          check("ovf", out_ovf, r.ovf);
          check("zero", out_zero, r.zero);
          check("tag", out_tag, r.tag);
        end
        last_r.diff = out_diff; last_r.borrow = out_borrow; last_r.ovf = out_ovf;
        last_r.zero = out_zero; last_r.tag = out_tag;
        tag_log.push_back(out_tag);
        n_out++;
      end
      held = out_valid && !out_ready;
      held_r.diff = out_diff; held_r.borrow = out_borrow; held_r.ovf = out_ovf;
      held_r.zero = out_zero; held_r.tag = out_tag;
      if (in_valid && in_ready) begin
        op = src_q.pop_front();
        exp_q.push_back(model(op));
        presenting = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      if (src_q.size() == 0 && !presenting && exp_q.size() == 0) break;
      cycle(1);
    end
    if (src_q.size() != 0 || presenting || exp_q.size() != 0)
      check(name, exp_q.size() + src_q.size(), 0);
  endtask

  task automatic check_last(input string name, input logic [15:0] diff, input logic borrow,
                            input logic ovf, input logic zero, input logic [3:0] tag);
    check({name, "_diff"}, last_r.diff, diff);
    check({name, "_flags"}, {last_r.borrow, last_r.ovf, last_r.zero}, {borrow, ovf, zero});
    check({name, "_tag"}, last_r.tag, tag);
  endtask

  initial begin
    int n0;
    int gen;

    @(negedge clk);
    rst_n = 1'b0;
    cycle(0);
    cycle(0);
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_out_flags", {out_borrow, out_ovf, out_zero}, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);

    // Latency and basic result
    out_ready = 1'b1;
    send(16'h0005, 16'h0003, 4'd1);
    cycle(1);
    check("lat_1", out_valid, 0);
    cycle(1);
    check("lat_2", out_valid, 0);
    cycle(1);
    check("lat_3", out_valid, 1);
    run_idle("basic_drain");
    check_last("basic", 16'h0002, 0, 0, 0, 4'd1);

    send(16'h0003, 16'h0005, 4'd2);
    run_idle("borrow_drain");
    check_last("borrow", 16'hFFFE, 1, 0, 0, 4'd2);

    send(16'h1234, 16'h1234, 4'd3);
    run_idle("equal_drain");
    check_last("equal", 16'h0000, 0, 0, 1, 4'd3);

    send(16'h8000, 16'h0001, 4'd4);
    run_idle("ovf_neg_drain");
    check_last("ovf_neg", 16'h7FFF, 0, 1, 0, 4'd4);

    send(16'h7FFF, 16'hFFFF, 4'd5);
    run_idle("ovf_pos_drain");
    check_last("ovf_pos", 16'h8000, 1, 1, 0, 4'd5);

    // Back-pressure: fill the pipe, stall, then release
    tag_log.delete();
    n0 = n_out;
    for (int i = 0; i < 5; i++) send(16'(i * 16'h0111 + 16'h0040), 16'(i * 16'h0023), 4'(i));
    cycle(1);
    cycle(1);
    out_ready = 1'b0;
    repeat (6) cycle(1);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_fill", exp_q.size(), 3);
    check("bp_none_out", n_out - n0, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    run_idle("bp_drain");
    check("bp_count", n_out - n0, 5);
    for (int i = 0; i < 5 && i < tag_log.size(); i++) check("bp_order", tag_log[i], i);

    // Reset while two operations are in flight
    send(16'h1111, 16'h0001, 4'd8);
    send(16'h2222, 16'h0002, 4'd9);
    cycle(1);
    cycle(1);
    rst_n = 1'b0;
    cycle(0);
    rst_n = 1'b1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_diff", out_diff, 0);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (4) cycle(0);
    check("rst_mid_quiet", out_valid, 0);
    send(16'h0100, 16'h00FF, 4'd7);
    run_idle("rst_new_drain");
    check_last("rst_new", 16'h0001, 0, 0, 0, 4'd7);

    // Randomized traffic with random valid/ready toggling
    n0 = n_out;
    gen = 0;
    for (int c = 0; c < 60000 && (gen < 10000 || src_q.size() > 0); c++) begin
      if (src_q.size() == 0 && gen < 10000) begin
        send(16'($urandom), 16'($urandom), 4'($urandom));
        gen++;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle($urandom_range(0, 9) < 7);
    end
    out_ready = 1'b1;
    run_idle("rand_drain");
    check("rand_count", n_out - n0, gen);
    check("rand_budget", gen, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_sub16_pipe.md
Name: prefix_sub16_pipe

Overview:
- Pipelined 16-bit unsigned/two's-complement subtractor, diff = a - b, built on the same g/p parallel-prefix carry network as the team's 16-bit prefix adder, run in the subtract direction: b inverted, carry-in forced to 1.
- Three register stages with valid/ready handshakes on both sides. Sits between operand producers and the compare/ALU datapath.
- Reports borrow, signed overflow and a zero flag.

Parameters:
WIDTH, 16, operand width. Prefix network sized for 16; other values are not supported and elaborate with an error.
TAG_W, 4, width of the sideband tag carried unchanged alongside each operation.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  minuend
in_b  input  WIDTH  subtrahend
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_diff  output  WIDTH  a - b mod 2^WIDTH
out_borrow  output  1  1 when a < b unsigned (inverted final carry)
out_ovf  output  1  signed overflow: a[15] != b[15] and diff[15] != a[15]
out_zero  output  1  diff == 0
out_tag  output  TAG_W  tag of this result

Behaviour:
- Stage 0 (S0): on accept, register g = a & ~b, p = a ^ ~b, a[15], b[15], tag.
- Stage 1 (S1): register group (G,P) after prefix levels 1-2: spans of 2 and 4, Kogge-Stone style. Carry-in 1 is folded in as g[-1] = 1.
- Stage 2 (S2): complete levels 3-4 (spans 8, 16). Then compute:
  - carries c[i] = G[i:-1]
  - diff[i] = p[i] ^ c[i-1], with c[-1] = 1
  - borrow = ~c[15]
  - ovf and zero as defined in Ports
  All results and the tag are registered in S2, which drives the out_* ports.
- Latency: 3 cycles from accepted input to out_valid when out_ready stays high. Throughput is one operation per cycle.
- Per-stage valid bits v0, v1, v2. Stage enables:
  - en2 = !v2 | out_ready
  - en1 = !v1 | en2
  - en0 = !v0 | en1
  - in_ready = en0, combinational from out_ready; there is no bubble insertion.
- A stage loads when its enable is high. Its valid bit takes the upstream valid; for S0 this is in_valid & in_ready.
- A stage whose enable is low holds its data and valid unchanged.
- out_valid = v2. While out_valid & !out_ready, all out_* ports are held stable.
- in_valid with in_ready low: the operand is not taken. The producer must hold it.
- Full pipe (v0 = v1 = v2 = 1) with out_ready = 0: in_ready = 0. When out_ready rises, the whole chain advances in that same cycle.
- Reset (rst_n = 0 at a clock edge), including mid-operation:
  - v0, v1, v2 cleared; in-flight operations are discarded, not flushed.
  - out_valid = 0; out_diff, out_borrow, out_ovf, out_zero, out_tag = 0.
  - in_ready = 1 from the first cycle after reset.
- Data registers clear on reset too, so out_* are deterministic.
- Arithmetic wraps modulo 2^16. No saturation.

Decomposition:
- Shared package prefix_pkg:
  - constant PFX_WIDTH = 16
  - typedef gp_t: struct with g and p vectors of PFX_WIDTH
  - function for the black-cell combine: G = Gi | Pi&Gj, P = Pi&Pj
- The adder family reuses this package.
- One sub-module, prefix_level: a single combinational Kogge-Stone level parameterised by span, taking gp_t in and giving gp_t out. Instantiated twice per prefix stage.
- The pipeline control stays in prefix_sub16_pipe.

Test Plan:
- Basic: a=0x0005, b=0x0003, tag=1, out_ready=1 -> 3 cycles later diff=0x0002, borrow=0, ovf=0, zero=0, tag=1.
- Borrow and equality: a=0x0003,b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0. Then a=b=0x1234 -> diff=0x0000, zero=1, borrow=0.
- Signed overflow:
  - a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, borrow=0
  - a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, borrow=1
- Back-pressure: stream 5 ops, hold out_ready=0 from cycle 2 -> pipe fills to 3, in_ready=0, out_* stable. Release -> all 5 results emerge in order with tags 0..4, none lost or duplicated.
- Reset mid-flight: 2 ops in flight, rst_n=0 for one cycle -> next cycle out_valid=0, out_diff=0, in_ready=1. A new op a=0x0100, b=0x00FF returns diff=0x0001 after 3 cycles.
- Random: 10k random a, b, tags with random in_valid/out_ready toggling, checked against a reference model of a-b, borrow, ovf and zero with order preserved.
